// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// UART_TX_PARITY_EN adds an even-parity bit and a PARITY FSM state.
package uart_tx_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_TXDATA = 2'd3;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_IE  = 1;
  localparam int unsigned CTRL_PAR = 2;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_FULL    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 8;

`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } tx_state_e;

  function automatic logic parity_even(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with first-word-fall-through head; DEPTH must be a power of two.
// Push while full is dropped; simultaneous push and pop keep the count.
module tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_dev.sv
// Bridge-attached 8N1 UART transmitter: register file, TX FIFO, bit timer, shifter.
// Optional even parity selected by UART_TX_PARITY_EN.
module uart_tx_dev
  import uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        TxD
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             en_q, en_d, ie_q, ie_d, ovf_q, ovf_d;
  logic [DIV_W-1:0] div_q, div_d;

  tx_state_e        state_q;
  logic             txd_q;
  logic [DIV_W-1:0] bitcnt_q;
  logic [7:0]       shreg_q;
  logic [2:0]       idx_q;
`ifdef UART_TX_PARITY_EN
  logic             par_q;
`endif

  logic             wr_ctrl, wr_status, wr_div, push, pop;
  logic             full, empty, busy, bit_end;
  logic [CNT_W-1:0] count;
  logic [7:0]       head;

  logic unused_bits;
  assign unused_bits = ^{Addr[29:2], Din};

  assign wr_ctrl   = WE & (Addr[1:0] == REG_CTRL);
  assign wr_status = WE & (Addr[1:0] == REG_STATUS);
  assign wr_div    = WE & (Addr[1:0] == REG_DIV);
  assign push      = WE & (Addr[1:0] == REG_TXDATA);

  assign busy    = (state_q != S_IDLE);
  assign bit_end = (bitcnt_q == '0);
  // Pops happen only from IDLE or at the last cycle of STOP, so a cleared EN
  // lets the current frame finish without starting another.
  assign pop     = en_q & ~empty &
                   ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_end));

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .wdata_i (Din[7:0]),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    en_d  = en_q;
    ie_d  = ie_q;
    div_d = div_q;
    ovf_d = ovf_q;
    if (wr_ctrl) begin
      en_d = Din[CTRL_EN];
      ie_d = Din[CTRL_IE];
    end
    if (wr_div) div_d = Din[DIV_W-1:0];
    if (wr_status && Din[ST_OVF]) ovf_d = 1'b0;
    if (push && full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q  <= 1'b0;
      ie_q  <= 1'b0;
      div_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      en_q  <= en_d;
      ie_q  <= ie_d;
      div_q <= div_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      txd_q    <= 1'b1;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      idx_q    <= '0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            state_q  <= S_START;
            txd_q    <= 1'b0;
            shreg_q  <= head;
            bitcnt_q <= div_q;
`ifdef UART_TX_PARITY_EN
            par_q    <= parity_even(head);
`endif
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q  <= S_DATA;
            txd_q    <= shreg_q[0];
            shreg_q  <= shreg_q >> 1;
            idx_q    <= '0;
            bitcnt_q <= div_q;
          end else begin
            bitcnt_q <= bitcnt_q - DIV_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bitcnt_q <= div_q;
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              txd_q   <= par_q;
`else
              state_q <= S_STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              idx_q   <= idx_q + 3'd1;
              txd_q   <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
            end
          end else begin
            bitcnt_q <= bitcnt_q - DIV_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state_q  <= S_STOP;
            txd_q    <= 1'b1;
            bitcnt_q <= div_q;
          end else begin
            bitcnt_q <= bitcnt_q - DIV_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            if (pop) begin
              state_q  <= S_START;
              txd_q    <= 1'b0;
              shreg_q  <= head;
              bitcnt_q <= div_q;
`ifdef UART_TX_PARITY_EN
              par_q    <= parity_even(head);
`endif
            end else begin
              state_q <= S_IDLE;
              txd_q   <= 1'b1;
            end
          end else begin
            bitcnt_q <= bitcnt_q - DIV_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr[1:0])
      REG_CTRL: begin
        Dout[CTRL_EN]  = en_q;
        Dout[CTRL_IE]  = ie_q;
        Dout[CTRL_PAR] = PARITY_EN;
      end
      REG_STATUS: begin
        Dout[ST_BUSY]                = busy;
        Dout[ST_EMPTY]               = empty;
        Dout[ST_FULL]                = full;
        Dout[ST_OVF]                 = ovf_q;
        Dout[ST_CNT_LSB +: CNT_W]    = count;
      end
      REG_DIV:  Dout[DIV_W-1:0] = div_q;
      default:  Dout = '0;
    endcase
  end

  assign TxD = txd_q;
  assign IRQ = ie_q & empty & ~busy;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed self-checking bench for uart_tx_dev (default and UART_TX_PARITY_EN builds).
module tb_uart_tx_dev;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic        IRQ;
  logic        TxD;

  int tests = 0;
  int fails = 0;

`ifdef UART_TX_PARITY_EN
  localparam int FLEN = 11;
  localparam logic [31:0] CAP = 32'h4;
`else
  localparam int FLEN = 10;
  localparam logic [31:0] CAP = 32'h0;
`endif

  uart_tx_dev #(
    .FIFO_DEPTH (8),
    .DIV_W      (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ),
    .TxD   (TxD)
  );

  always #5 clk = ~clk;

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge and the
  // task returns at the negedge after it.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = {28'd0, a};
    Din  = d;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    Addr = {28'd0, a};
    #1;
    chk(tag, Dout, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] b, input int div);
    wr(2'd3, {24'd0, b});
    rd_chk("queued", 2'd1, 32'h0000_0100);
    for (int k = 1; k <= FLEN * (div + 1); k++) begin
      @(negedge clk);
      chk("txd_bit", {31'd0, TxD}, {31'd0, frame_bit(b, (k - 1) / (div + 1))});
      Addr = 30'd1;
      #1;
      chk("busy", {31'd0, Dout[0]}, 32'd1);
    end
    @(negedge clk);
    chk("txd_idle", {31'd0, TxD}, 32'd1);
    rd_chk("status_done", 2'd1, 32'h0000_0002);
  endtask

  initial begin
    logic [7:0] b;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rd_chk("rst_ctrl", 2'd0, CAP);
    rd_chk("rst_status", 2'd1, 32'h0000_0002);
    rd_chk("rst_div", 2'd2, 32'h0);
    rd_chk("rst_txdata", 2'd3, 32'h0);
    chk("rst_txd", {31'd0, TxD}, 32'd1);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);

    // Single frame, DIV=3
    @(negedge clk);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'h1);
    rd_chk("div_rb", 2'd2, 32'd3);
    rd_chk("ctrl_rb", 2'd0, CAP | 32'h1);
    @(negedge clk);
    run_frame(8'hA5, 3);
`ifdef UART_TX_PARITY_EN
    @(negedge clk);
    run_frame(8'h07, 3);
`endif

    // Overflow with EN=0
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 8; i++) wr(2'd3, i);
    rd_chk("full_no_ovf", 2'd1, 32'h0000_0804);
    wr(2'd3, 32'h99);
    rd_chk("full_ovf", 2'd1, 32'h0000_080C);
    @(negedge clk);
    wr(2'd1, 32'h8);
    rd_chk("ovf_clear", 2'd1, 32'h0000_0804);

    // Back-to-back frames with IRQ at drain, DIV=1
    @(negedge clk);
    do_reset();
    wr(2'd2, 32'd1);
    wr(2'd3, 32'h3C);
    wr(2'd3, 32'h81);
    wr(2'd0, 32'h3);
    chk("irq_pending", {31'd0, IRQ}, 32'd0);
    for (int k = 1; k <= 4 * FLEN; k++) begin
      @(negedge clk);
      b = (k - 1 < 2 * FLEN) ? 8'h3C : 8'h81;
      chk("b2b_txd", {31'd0, TxD}, {31'd0, frame_bit(b, ((k - 1) % (2 * FLEN)) / 2)});
      chk("b2b_irq_low", {31'd0, IRQ}, 32'd0);
    end
    @(negedge clk);
    chk("irq_high", {31'd0, IRQ}, 32'd1);
    rd_chk("b2b_status", 2'd1, 32'h0000_0002);
    @(negedge clk);
    chk("irq_holds", {31'd0, IRQ}, 32'd1);
    wr(2'd3, 32'h55);
    chk("irq_cleared_by_write", {31'd0, IRQ}, 32'd0);

    // Clear EN mid-DATA with a second frame queued, DIV=1
    @(negedge clk);
    do_reset();
    wr(2'd2, 32'd1);
    wr(2'd3, 32'hF0);
    wr(2'd3, 32'h0F);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 5; k++) @(negedge clk);
    chk("en_off_in_data", {31'd0, TxD}, {31'd0, frame_bit(8'hF0, 2)});
    wr(2'd0, 32'h0);
    for (int k = 7; k <= 2 * FLEN; k++) begin
      @(negedge clk);
      chk("en_off_txd", {31'd0, TxD}, {31'd0, frame_bit(8'hF0, (k - 1) / 2)});
    end
    @(negedge clk);
    rd_chk("en_off_status", 2'd1, 32'h0000_0100);
    for (int k = 0; k < 10; k++) @(negedge clk);
    rd_chk("en_off_no_send", 2'd1, 32'h0000_0100);
    chk("en_off_txd_idle", {31'd0, TxD}, 32'd1);

    // Asynchronous reset mid-DATA
    @(negedge clk);
    do_reset();
    wr(2'd2, 32'd3);
    wr(2'd0, 32'h1);
    wr(2'd3, 32'h00);
    for (int k = 1; k <= 10; k++) @(negedge clk);
    chk("pre_reset_txd", {31'd0, TxD}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_txd", {31'd0, TxD}, 32'd1);
    chk("async_reset_irq", {31'd0, IRQ}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rd_chk("post_reset_status", 2'd1, 32'h0000_0002);
    rd_chk("post_reset_ctrl", 2'd0, CAP);
    rd_chk("post_reset_div", 2'd2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
